loader_address_sequencer: RTL and testbench
===========================================

LOADER_ADDRESS_SEQUENCER -- requirements
Module: loader_address_sequencer

Interface
REQ-001 Parameter ADDRESS_SIZE, default 10: width of the word-address bus.
REQ-002 Parameter TOTAL_WORDS, default 12: number of addressable words in the strobe loader; addresses wrap modulo this value.
REQ-003 CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 RESET  input  1  asynchronous, active-high reset.
REQ-005 START  input  1  request to begin a burst; sampled only in IDLE.
REQ-006 BASE  input  ADDRESS_SIZE  first word address of the burst; sampled with START.
REQ-007 COUNT  input  ADDRESS_SIZE  number of words in the burst; sampled with START.
REQ-008 READY  input  1  the loader accepts the current word when ENABLE and READY are both high at a rising edge.
REQ-009 ADDRESS  output  ADDRESS_SIZE  registered word address presented to the loader.
REQ-010 ENABLE  output  1  registered valid qualifier for ADDRESS.
REQ-011 BUSY  output  1  high while a burst is in progress.
REQ-012 DONE  output  1  one-cycle pulse at burst completion.
REQ-013 ERROR  output  1  one-cycle pulse, coincident with DONE, for a rejected burst.

Function
REQ-014 The FSM SHALL have the states IDLE, ISSUE, GAP (present only when the macro is defined) and FINISH.
REQ-015 IDLE: when START=1, latch BASE and COUNT, then go to ISSUE, or to FINISH if COUNT=0 or BASE>=TOTAL_WORDS.
REQ-016 ENABLE SHALL rise in the first cycle after START is sampled, with ADDRESS=BASE.
REQ-017 ISSUE: ADDRESS and ENABLE SHALL hold stable while READY=0 (no skip, no change).
REQ-018 On acceptance: the remaining count decrements; ADDRESS advances by 1, or wraps from TOTAL_WORDS-1 to 0.
REQ-019 Acceptance of the last word SHALL move the FSM to FINISH, with ENABLE low in the next cycle.
REQ-020 With the macro undefined, non-final words SHALL issue back-to-back: one word per cycle when READY=1.
REQ-021 FINISH SHALL last exactly one cycle, with DONE=1, then return to IDLE.
REQ-022 ERROR SHALL be 1 in FINISH only when the burst was rejected for BASE>=TOTAL_WORDS; ENABLE is never asserted for such a burst.
REQ-023 COUNT=0 SHALL produce DONE one cycle after START, with ENABLE never asserted and ERROR=0.
REQ-024 BUSY SHALL be 1 in ISSUE, GAP and FINISH, and 0 in IDLE.
REQ-025 START asserted while not in IDLE SHALL be ignored; it is not queued.
REQ-026 The internal remaining-count and address arithmetic SHALL be ADDRESS_SIZE bits wide and unsigned; wrap SHALL be by compare-and-clear, not by modulo division.

Reset
REQ-027 RESET=1 SHALL immediately force IDLE and ADDRESS=0, ENABLE=0, BUSY=0, DONE=0, ERROR=0, independent of CLK.
REQ-028 Reset mid-burst SHALL abandon the burst with no DONE pulse.
REQ-029 After RESET deasserts, the first START SHALL be honoured at the first rising edge.

Configuration
REQ-030 The macro LOADER_SEQ_GAP_EN SHALL control the GAP state and nothing else.
REQ-031 With LOADER_SEQ_GAP_EN defined: after each accepted non-final word the FSM enters GAP for one cycle with ENABLE=0 and ADDRESS already advanced, then returns to ISSUE. This guarantees an ENABLE edge per word for edge-sensitive loaders.
REQ-032 With LOADER_SEQ_GAP_EN undefined: the GAP state is not compiled in and behaviour is per REQ-020.

Verification
REQ-033 TOTAL_WORDS=12, BASE=3, COUNT=4, READY=1 -> ADDRESS 3,4,5,6 with ENABLE=1 on 4 consecutive cycles; DONE=1 the next cycle; BUSY=1 for 5 cycles.
REQ-034 BASE=10, COUNT=4, READY=1 -> ADDRESS 10,11,0,1; DONE once; ERROR=0.
REQ-035 BASE=2, COUNT=3, READY=0 for 3 cycles during word 2 -> ADDRESS=3 with ENABLE=1 held for 4 cycles; sequence 2,3,4 completes with DONE.
REQ-036 Case A: COUNT=0 -> DONE=1, ERROR=0 one cycle after START, ENABLE stays 0. Case B: BASE=12 -> DONE=1 and ERROR=1 one cycle after START, ENABLE stays 0.
REQ-037 RESET pulsed mid-burst (BASE=0, COUNT=8, after 3 words) -> all outputs 0 without waiting for a CLK edge; no DONE; a new START, BASE=5, COUNT=1 -> ADDRESS=5, then DONE.
REQ-038 LOADER_SEQ_GAP_EN defined, BASE=0, COUNT=3, READY=1 -> ENABLE pattern 1,0,1,0,1 with ADDRESS 0,1,1,2,2, then DONE.

Source files
------------

// File: rtl/loader_address_sequencer_if.sv
// loader_address_sequencer_if: burst request and word-address handshake bundle
//   START/BASE/COUNT : burst request (master -> sequencer)
//   READY            : loader accepts the current word (master -> sequencer)
//   ADDRESS/ENABLE   : registered word address and its valid qualifier
//   BUSY/DONE/ERROR  : burst status; DONE and ERROR are one-cycle pulses
interface loader_address_sequencer_if #(
    parameter int ADDRESS_SIZE = 10
);
    logic                    START;
    logic [ADDRESS_SIZE-1:0] BASE;
    logic [ADDRESS_SIZE-1:0] COUNT;
    logic                    READY;
    logic [ADDRESS_SIZE-1:0] ADDRESS;
    logic                    ENABLE;
    logic                    BUSY;
    logic                    DONE;
    logic                    ERROR;
    modport master (
        output START, BASE, COUNT, READY,
        input  ADDRESS, ENABLE, BUSY, DONE, ERROR
    );
    modport slave (
        input  START, BASE, COUNT, READY,
        output ADDRESS, ENABLE, BUSY, DONE, ERROR
    );
endinterface

// File: rtl/loader_address_sequencer.sv
// loader_address_sequencer: issues a burst of wrapping word addresses to a strobe loader
//   CLK   : clock, all state on rising edge
//   RESET : asynchronous active-high reset
//   bus   : loader_address_sequencer_if.slave (request, handshake and status)
//   Optional macro LOADER_SEQ_GAP_EN inserts an ENABLE-low GAP cycle after each
//   accepted non-final word so edge-sensitive loaders see one ENABLE edge per word.
module loader_address_sequencer #(
    parameter int ADDRESS_SIZE = 10,
    parameter int TOTAL_WORDS  = 12
) (
    input logic CLK,
    input logic RESET,
    loader_address_sequencer_if.slave bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ISSUE  = 2'd1;
`ifdef LOADER_SEQ_GAP_EN
    localparam logic [1:0] GAP    = 2'd2;
`endif
    localparam logic [1:0] FINISH = 2'd3;
    localparam logic [ADDRESS_SIZE-1:0] LAST  = ADDRESS_SIZE'(TOTAL_WORDS - 1);
    localparam logic [ADDRESS_SIZE:0]   LIMIT = (ADDRESS_SIZE + 1)'(TOTAL_WORDS);

    logic [1:0]              state;
    logic [ADDRESS_SIZE-1:0] address;
    logic [ADDRESS_SIZE-1:0] remaining;
    logic                    enable;
    logic                    busy;
    logic                    done;
    logic                    error;
    logic                    out_of_range;
    logic                    last_word;
    logic [ADDRESS_SIZE-1:0] next_address;

    // one extra bit so TOTAL_WORDS == 2**ADDRESS_SIZE still compares correctly
    assign out_of_range = {1'b0, bus.BASE} >= LIMIT;
    assign next_address = (address == LAST) ? '0 : address + 1'b1;
    assign last_word    = remaining == ADDRESS_SIZE'(1);

    assign bus.ADDRESS = address;
    assign bus.ENABLE  = enable;
    assign bus.BUSY    = busy;
    assign bus.DONE    = done;
    assign bus.ERROR   = error;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            address   <= '0;
            remaining <= '0;
            enable    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.START) begin
                    address   <= bus.BASE;
                    remaining <= bus.COUNT;
                    busy      <= 1'b1;
                    if (bus.COUNT == '0 || out_of_range) begin
                        state <= FINISH;
                        done  <= 1'b1;
                        error <= out_of_range;
                    end else begin
                        state  <= ISSUE;
                        enable <= 1'b1;
                    end
                end
                ISSUE: if (bus.READY) begin
                    address   <= next_address;
                    remaining <= remaining - 1'b1;
                    if (last_word) begin
                        state  <= FINISH;
                        enable <= 1'b0;
                        done   <= 1'b1;
                    end
`ifdef LOADER_SEQ_GAP_EN
                    else begin
                        state  <= GAP;
                        enable <= 1'b0;
                    end
`endif
                end
`ifdef LOADER_SEQ_GAP_EN
                GAP: begin
                    state  <= ISSUE;
                    enable <= 1'b1;
                end
`endif
                FINISH: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    error <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_loader_address_sequencer.sv
// tb_loader_address_sequencer: directed scoreboard bench for loader_address_sequencer
module tb_loader_address_sequencer;
    localparam int AS = 10;
    localparam int TW = 12;
`ifdef LOADER_SEQ_GAP_EN
    localparam int GAP = 1;
`else
    localparam int GAP = 0;
`endif

    logic CLK = 1'b0;
    logic RESET = 1'b0;
    always #5 CLK = ~CLK;

    loader_address_sequencer_if #(.ADDRESS_SIZE(AS)) bus ();
    loader_address_sequencer #(.ADDRESS_SIZE(AS), .TOTAL_WORDS(TW)) dut (
        .CLK(CLK),
        .RESET(RESET),
        .bus(bus.slave)
    );

    int tests = 0;
    int fails = 0;
    logic [AS-1:0] exp_q[$];
    logic [AS-1:0] addr_log[$];
    logic [15:0] en_pat;
    int en_cycles, busy_cycles, err_cnt, done_at, hold_cycles;

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // drive a request for one cycle and push the addresses the loader should receive
    task automatic start_burst(input int base, input int count);
        bus.START = 1'b1;
        bus.BASE  = base[AS-1:0];
        bus.COUNT = count[AS-1:0];
        if (count > 0 && base < TW)
            for (int i = 0; i < count; i++) exp_q.push_back(AS'((base + i) % TW));
        @(negedge CLK);
        bus.START = 1'b0;
    endtask

    // observe one burst at negedges until DONE; optional READY stall and ignored START
    task automatic run_burst(input int max_cyc, input int stall_idx, input int stall_len, input bit poke);
        int words, stalled;
        bit saw_done;
        words = 0; stalled = 0; saw_done = 0;
        en_cycles = 0; busy_cycles = 0; err_cnt = 0; done_at = -1; hold_cycles = 0; en_pat = '0;
        addr_log.delete();
        for (int c = 0; c < max_cyc && !saw_done; c++) begin
            bus.START = poke && c == 0;
            if (poke && c == 0) begin
                bus.BASE  = 7;
                bus.COUNT = 5;
            end
            bus.READY = !(bus.ENABLE && words == stall_idx && stalled < stall_len);
            if (!bus.READY) stalled++;
            en_pat = {en_pat[14:0], bus.ENABLE};
            addr_log.push_back(bus.ADDRESS);
            en_cycles   += int'(bus.ENABLE);
            busy_cycles += int'(bus.BUSY);
            err_cnt     += int'(bus.ERROR);
            if (bus.DONE) begin
                done_at  = c;
                saw_done = 1;
            end
            if (bus.ENABLE) begin
                if (words == stall_idx) hold_cycles++;
                if (exp_q.size() == 0) chk("word_queue_empty", exp_q.size(), 1);
                else begin
                    chk("address", int'(bus.ADDRESS), int'(exp_q[0]));
                    if (bus.READY) begin
                        void'(exp_q.pop_front());
                        words++;
                    end
                end
            end
            @(negedge CLK);
        end
        bus.START = 1'b0;
        bus.READY = 1'b1;
        chk("done_seen", int'(saw_done), 1);
        chk("done_pulse_width", int'(bus.DONE), 0);
        chk("idle_after_done", int'(bus.BUSY), 0);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_address"}, int'(bus.ADDRESS), 0);
        chk({tag, "_enable"}, int'(bus.ENABLE), 0);
        chk({tag, "_busy"}, int'(bus.BUSY), 0);
        chk({tag, "_done"}, int'(bus.DONE), 0);
        chk({tag, "_error"}, int'(bus.ERROR), 0);
    endtask

    initial begin
        bus.START = 1'b0;
        bus.BASE  = '0;
        bus.COUNT = '0;
        bus.READY = 1'b1;
        #1 RESET = 1'b1;
        #1 chk_outputs_zero("reset");
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b0;

        // basic burst 3,4,5,6
        start_burst(3, 4);
        run_burst(40, -1, 0, 0);
        chk("b1_enable_cycles", en_cycles, 4);
        chk("b1_done_at", done_at, 4 + 3 * GAP);
        chk("b1_busy_cycles", busy_cycles, 5 + 3 * GAP);
        chk("b1_error", err_cnt, 0);

        // wrap 10,11,0,1
        start_burst(10, 4);
        run_burst(40, -1, 0, 0);
        chk("wrap_enable_cycles", en_cycles, 4);
        chk("wrap_error", err_cnt, 0);

        // stall three cycles on the second word
        start_burst(2, 3);
        run_burst(40, 1, 3, 0);
        chk("stall_hold_cycles", hold_cycles, 4);
        chk("stall_done_at", done_at, 6 + 2 * GAP);

        // zero-length burst
        start_burst(5, 0);
        run_burst(10, -1, 0, 0);
        chk("zero_done_at", done_at, 0);
        chk("zero_enable", en_cycles, 0);
        chk("zero_error", err_cnt, 0);

        // out-of-range base, at the boundary and at the top of the bus
        start_burst(12, 3);
        run_burst(10, -1, 0, 0);
        chk("range_done_at", done_at, 0);
        chk("range_enable", en_cycles, 0);
        chk("range_error", err_cnt, 1);
        start_burst(1023, 1);
        run_burst(10, -1, 0, 0);
        chk("range_max_error", err_cnt, 1);
        chk("range_max_enable", en_cycles, 0);

        // last valid base wraps immediately
        start_burst(11, 2);
        run_burst(20, -1, 0, 0);
        chk("last_base_error", err_cnt, 0);

        // START while busy is ignored and not queued
        start_burst(0, 2);
        run_burst(20, -1, 0, 1);
        chk("poke_done_at", done_at, 2 + GAP);
        @(negedge CLK);
        chk("poke_not_queued_busy", int'(bus.BUSY), 0);
        chk("poke_not_queued_enable", int'(bus.ENABLE), 0);

        // ENABLE and ADDRESS pattern for a three-word burst
        start_burst(0, 3);
        run_burst(20, -1, 0, 0);
`ifdef LOADER_SEQ_GAP_EN
        chk("pattern_enable", int'(en_pat[5:0]), 6'b101010);
        chk("pattern_len", addr_log.size(), 6);
        chk("pattern_a1", int'(addr_log[1]), 1);
        chk("pattern_a2", int'(addr_log[2]), 1);
        chk("pattern_a3", int'(addr_log[3]), 2);
        chk("pattern_a4", int'(addr_log[4]), 2);
`else
        chk("pattern_enable", int'(en_pat[3:0]), 4'b1110);
        chk("pattern_len", addr_log.size(), 4);
        chk("pattern_a1", int'(addr_log[1]), 1);
        chk("pattern_a2", int'(addr_log[2]), 2);
`endif

        // reset mid-burst after three words
        start_burst(0, 8);
        for (int c = 0; c < 3; c++) begin
            if (GAP != 0 && !bus.ENABLE) @(negedge CLK);
            chk("rst_burst_enable", int'(bus.ENABLE), 1);
            chk("rst_burst_address", int'(bus.ADDRESS), int'(exp_q[0]));
            void'(exp_q.pop_front());
            @(negedge CLK);
        end
        #2 RESET = 1'b1;
        #1 chk_outputs_zero("async_reset");
        exp_q.delete();
        for (int c = 0; c < 2; c++) begin
            @(negedge CLK);
            chk("reset_no_done", int'(bus.DONE), 0);
        end
        RESET = 1'b0;
        start_burst(5, 1);
        run_burst(10, -1, 0, 0);
        chk("after_reset_done_at", done_at, 1);
        chk("after_reset_enable", en_cycles, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
